alu_matrix_loader: RTL and testbench
====================================

# alu_matrix_loader

Upstream operand-assembly stage for the matrix ALU. It accepts signed 8-bit elements one per beat over a valid/ready stream and places each element into a 5x5 row-major 200-bit flat matrix. For matrix orders 2 to 5, unused positions are zero-filled. Once the last element is stored, it presents the complete matrix to the element-wise ALU modules (negation, etc.) with a valid/ready handshake.

## Interface
- ELEM_W, 8, element width in bits (signed two's complement); fixed, not overridable in this release
- DIM, 5, maximum matrix order; flat layout is always DIM x DIM

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a new load; honoured only in IDLE
- size  in  3  matrix order n, sampled on accepted start; legal 2..5
- in_data  in  8  element value, row-major order
- in_valid  in  1  in_data is valid
- in_ready  out  1  loader accepts an element this cycle
- mat_flat  out  200  assembled matrix; element (r,c) at bits [(r*5+c)*8 +: 8]
- mat_valid  out  1  mat_flat is complete and stable
- mat_ready  in  1  consumer takes the matrix
- busy  out  1  high in LOAD or HOLD
- err_size  out  1  one-cycle pulse when start is accepted with an illegal size

## Operation
- States:
  - IDLE: in_ready=0, mat_valid=0.
  - LOAD: in_ready=1.
  - HOLD: mat_valid=1, in_ready=0.
- IDLE, start=1, size in 2..5:
  - latch n=size
  - clear the whole 200-bit buffer to 0
  - row=0, col=0
  - go to LOAD
- IDLE, start=1, size in {0,1,6,7:
  - err_size=1 for the next cycle only
  - stay IDLE; buffer untouched
- LOAD, in_valid=1:
  - write in_data to position row*5+col
  - if col==n-1: col=0, row=row+1; else col=col+1
  - if (row,col)==(n-1,n-1): go to HOLD instead of incrementing
- LOAD, in_valid=0: no change; wait indefinitely.
- HOLD, mat_ready=1: go to IDLE. mat_flat keeps its contents until the next accepted start.
- HOLD, mat_ready=0: mat_flat and mat_valid are held stable.
- start is ignored in LOAD and HOLD, with no error pulse.
- Positions with row>=n or col>=n always read 0 for the loaded matrix.
- Element values are stored verbatim, including 8'h80. Overflow detection belongs to the downstream ALU.

## Timing
- Reset (async assert, sync-safe deassert):
  - state=IDLE, buffer=0, row=col=0, n=0
  - in_ready=0, mat_valid=0, busy=0, err_size=0, mat_flat=200'b0
- Start accepted in cycle t: busy=1 and in_ready=1 from t+1.
- Element transfer occurs in each cycle where in_valid && in_ready at the rising edge. Full throughput is one element per cycle.
- Last element accepted in cycle t:
  - in_ready=0 and mat_valid=1 from t+1
  - minimum load time is n*n cycles after LOAD entry
- mat_ready while mat_valid=1 in cycle t: mat_valid=0 and busy=0 from t+1. The earliest next start is accepted at t+1.
- mat_ready while not in HOLD is ignored.
- Reset asserted mid-LOAD or mid-HOLD: immediate return to reset values. The partial matrix is discarded.
- All outputs are registered except in_ready, mat_valid and busy, which are decoded from registered state only. There is no combinational path from inputs to outputs.

## Test plan
- Reset then idle:
  - rst_n low, then high
  - require mat_flat=0, in_ready=0, mat_valid=0, busy=0
  - start with in_valid=1 and no size change does not load anything
- Full 5x5 load:
  - start size=5, stream 25 elements 8'd1..8'd25 back-to-back
  - mat_valid rises exactly 25 cycles after LOAD entry
  - mat_flat[7:0]=1, [199:192]=25
  - holds 5 cycles with mat_ready=0, then clears one cycle after mat_ready=1
- 3x3 with gaps:
  - start size=3, stream 9 elements 8'h80,8'h7F,... with in_valid deasserted every other cycle
  - (0,0)=8'h80, (0,1)=8'h7F, (1,0) lands at bits [47:40]
  - row 3, row 4 and columns 3-4 are all zero
- Illegal sizes:
  - start with size=1 -> err_size one-cycle pulse, state stays IDLE
  - start with size=7 -> err_size one-cycle pulse, state stays IDLE
  - previous mat_flat is unchanged in both cases
- Start ignored:
  - start size=2 mid-LOAD -> no restart, n stays as originally latched
  - start during HOLD -> no effect, no err_size
- Reset mid-operation:
  - assert rst_n low after 10 of 16 elements (size=4)
  - outputs immediately return to reset values
  - a fresh 4x4 load then completes correctly

Source files
------------

// File: rtl/alu_matrix_loader.sv
// -----------------------------------------------------------------------------
// alu_matrix_loader
//
// Operand-assembly stage for the matrix ALU. Signed 8-bit elements arrive one
// per beat on a valid/ready stream and are placed row-major into a 5x5 flat
// matrix (element (r,c) at bits [(r*5+c)*8 +: 8]). For orders 2..4 the unused
// positions stay zero because the whole buffer is cleared when a load starts.
// After the last element, the matrix is offered downstream with mat_valid and
// held until mat_ready.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   request a new load (honoured only when idle)
//   size [2:0] in   matrix order n, legal 2..5, sampled with start
//   in_data    in   signed element, row-major order
//   in_valid   in   in_data valid
//   in_ready   out  loader accepts an element this cycle
//   mat_flat   out  200-bit assembled matrix (registered)
//   mat_valid  out  mat_flat complete and stable
//   mat_ready  in   consumer takes the matrix
//   busy       out  load or hold in progress
//   err_size   out  one-cycle pulse after a start with an illegal size
// -----------------------------------------------------------------------------
module alu_matrix_loader (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2:0]          size,
  input  logic signed [7:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [199:0]        mat_flat,
  output logic                mat_valid,
  input  logic                mat_ready,
  output logic                busy,
  output logic                err_size
);

  localparam int ELEM_W = 8;
  localparam int DIM    = 5;
  localparam int FLAT_W = DIM * DIM * ELEM_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          n_q, n_d;
  logic [2:0]          row_q, row_d;
  logic [2:0]          col_q, col_d;
  logic [FLAT_W-1:0]   buf_q, buf_d;
  logic                err_q, err_d;

  logic [4:0]          wr_idx;
  logic [7:0]          wr_lsb;
  logic                last_col;
  logic                last_row;

  function automatic logic size_legal(input logic [2:0] s);
    return (s >= 3'd2) && (s <= 3'd5);
  endfunction

  // Flat position of the current write cursor; the buffer stride is always
  // DIM regardless of the loaded order.
  assign wr_idx   = 5'(row_q) * 5'd5 + 5'(col_q);
  assign wr_lsb   = {wr_idx, 3'b000};
  assign last_col = (col_q == n_q - 3'd1);
  assign last_row = (row_q == n_q - 3'd1);

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    row_d   = row_q;
    col_d   = col_q;
    buf_d   = buf_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (size_legal(size)) begin
            n_d     = size;
            buf_d   = '0;
            row_d   = 3'd0;
            col_d   = 3'd0;
            state_d = S_LOAD;
          end else begin
            err_d   = 1'b1;
          end
        end
      end

      S_LOAD: begin
        if (in_valid) begin
          buf_d[wr_lsb +: ELEM_W] = in_data;
          // Cursor stays on the final position when entering HOLD.
          if (last_row && last_col) begin
            state_d = S_HOLD;
          end else if (last_col) begin
            col_d = 3'd0;
            row_d = row_q + 3'd1;
          end else begin
            col_d = col_q + 3'd1;
          end
        end
      end

      S_HOLD: begin
        if (mat_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      n_q     <= 3'd0;
      row_q   <= 3'd0;
      col_q   <= 3'd0;
      buf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      row_q   <= row_d;
      col_q   <= col_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
    end
  end

  // Handshake outputs decode registered state only.
  assign in_ready  = (state_q == S_LOAD);
  assign mat_valid = (state_q == S_HOLD);
  assign busy      = (state_q != S_IDLE);
  assign mat_flat  = buf_q;
  assign err_size  = err_q;

endmodule

// File: tb/tb_alu_matrix_loader.sv
// -----------------------------------------------------------------------------
// tb_alu_matrix_loader
//
// Directed bench for alu_matrix_loader. Inputs change and outputs are sampled
// 1 ns after each rising clock edge. Expected matrices are built by the bench
// from the element sequence and the matrix order.
// -----------------------------------------------------------------------------
module tb_alu_matrix_loader;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic [2:0]          size;
  logic signed [7:0]   in_data;
  logic                in_valid;
  logic                in_ready;
  logic [199:0]        mat_flat;
  logic                mat_valid;
  logic                mat_ready;
  logic                busy;
  logic                err_size;

  int checks;
  int errors;

  logic [199:0] exp_mat;
  logic [199:0] saved_mat;
  logic [199:0] mask3;
  logic [7:0]   vec3 [9];

  alu_matrix_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .size      (size),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mat_flat  (mat_flat),
    .mat_valid (mat_valid),
    .mat_ready (mat_ready),
    .busy      (busy),
    .err_size  (err_size)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Place element number k (0-based, row-major within an n x n matrix).
  task automatic put_exp(input int k, input int n, input logic [7:0] v);
    int pos;
    pos = (k / n) * 5 + (k % n);
    exp_mat[pos*8 +: 8] = v;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    size      = 3'd0;
    in_data   = 8'sd0;
    in_valid  = 1'b0;
    mat_ready = 1'b0;
    vec3      = '{8'h80, 8'h7F, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};

    // ---------------- reset then idle ----------------
    tick();
    tick();
    chk("rst_mat_flat",  mat_flat,  200'd0);
    chk("rst_in_ready",  {199'd0, in_ready},  200'd0);
    chk("rst_mat_valid", {199'd0, mat_valid}, 200'd0);
    chk("rst_busy",      {199'd0, busy},      200'd0);
    chk("rst_err_size",  {199'd0, err_size},  200'd0);
    rst_n = 1'b1;
    tick();
    in_valid = 1'b1;
    in_data  = 8'sh55;
    tick();
    tick();
    chk("idle_no_load_flat",  mat_flat, 200'd0);
    chk("idle_no_load_ready", {199'd0, in_ready}, 200'd0);
    chk("idle_no_load_busy",  {199'd0, busy},     200'd0);
    in_valid = 1'b0;

    // ---------------- full 5x5 load ----------------
    start = 1'b1;
    size  = 3'd5;
    tick();
    start = 1'b0;
    chk("load5_busy",     {199'd0, busy},     200'd1);
    chk("load5_in_ready", {199'd0, in_ready}, 200'd1);
    exp_mat = '0;
    for (int i = 1; i <= 25; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      put_exp(i - 1, 5, 8'(i));
      tick();
      if (i == 24) chk("load5_not_valid_at_24", {199'd0, mat_valid}, 200'd0);
    end
    in_valid = 1'b0;
    chk("load5_valid_at_25",  {199'd0, mat_valid}, 200'd1);
    chk("load5_ready_low",    {199'd0, in_ready},  200'd0);
    chk("load5_first_elem",   {192'd0, mat_flat[7:0]},     {192'd0, 8'd1});
    chk("load5_last_elem",    {192'd0, mat_flat[199:192]}, {192'd0, 8'd25});
    chk("load5_matrix",       mat_flat, exp_mat);
    for (int h = 0; h < 5; h++) begin
      tick();
    end
    chk("load5_hold_valid", {199'd0, mat_valid}, 200'd1);
    chk("load5_hold_flat",  mat_flat, exp_mat);
    mat_ready = 1'b1;
    tick();
    mat_ready = 1'b0;
    chk("load5_release_valid", {199'd0, mat_valid}, 200'd0);
    chk("load5_release_busy",  {199'd0, busy},      200'd0);
    chk("load5_flat_kept",     mat_flat, exp_mat);

    // ---------------- 3x3 with gaps ----------------
    start = 1'b1;
    size  = 3'd3;
    tick();
    start = 1'b0;
    chk("load3_cleared", mat_flat, 200'd0);
    exp_mat = '0;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_data  = vec3[i];
      put_exp(i, 3, vec3[i]);
      tick();
      in_valid = 1'b0;
      if (i < 8) begin
        tick();
        if (i == 7) chk("load3_not_valid_at_8", {199'd0, mat_valid}, 200'd0);
      end
    end
    chk("load3_valid",    {199'd0, mat_valid}, 200'd1);
    chk("load3_e00",      {192'd0, mat_flat[7:0]},   {192'd0, 8'h80});
    chk("load3_e01",      {192'd0, mat_flat[15:8]},  {192'd0, 8'h7F});
    chk("load3_e10",      {192'd0, mat_flat[47:40]}, {192'd0, 8'h02});
    chk("load3_e22",      {192'd0, mat_flat[103:96]}, {192'd0, 8'h07});
    mask3 = '1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        mask3[(r*5+c)*8 +: 8] = 8'h00;
    chk("load3_unused_zero", mat_flat & mask3, 200'd0);
    chk("load3_matrix",      mat_flat, exp_mat);

    // start during HOLD is ignored, no error pulse
    start = 1'b1;
    size  = 3'd2;
    tick();
    start = 1'b0;
    chk("hold_start_err",   {199'd0, err_size},  200'd0);
    chk("hold_start_valid", {199'd0, mat_valid}, 200'd1);
    chk("hold_start_flat",  mat_flat, exp_mat);
    tick();
    chk("hold_start_err2",  {199'd0, err_size},  200'd0);
    mat_ready = 1'b1;
    tick();
    mat_ready = 1'b0;
    chk("load3_release_valid", {199'd0, mat_valid}, 200'd0);
    saved_mat = exp_mat;

    // ---------------- illegal sizes ----------------
    start = 1'b1;
    size  = 3'd1;
    tick();
    start = 1'b0;
    chk("size1_err_pulse", {199'd0, err_size}, 200'd1);
    chk("size1_idle",      {199'd0, busy},     200'd0);
    tick();
    chk("size1_err_clear", {199'd0, err_size}, 200'd0);
    chk("size1_flat_kept", mat_flat, saved_mat);
    start = 1'b1;
    size  = 3'd7;
    tick();
    start = 1'b0;
    chk("size7_err_pulse", {199'd0, err_size}, 200'd1);
    chk("size7_idle",      {199'd0, in_ready}, 200'd0);
    tick();
    chk("size7_err_clear", {199'd0, err_size}, 200'd0);
    chk("size7_flat_kept", mat_flat, saved_mat);

    // ---------------- start ignored mid-LOAD ----------------
    start = 1'b1;
    size  = 3'd4;
    tick();
    start = 1'b0;
    exp_mat = '0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h10 + i);
      put_exp(i, 4, 8'(8'h10 + i));
      if (i == 3) begin
        start = 1'b1;
        size  = 3'd2;
      end
      tick();
      start = 1'b0;
      if (i == 3) chk("midload_start_err", {199'd0, err_size}, 200'd0);
      if (i == 14) chk("midload_not_valid_at_15", {199'd0, mat_valid}, 200'd0);
    end
    in_valid = 1'b0;
    chk("midload_valid",  {199'd0, mat_valid}, 200'd1);
    chk("midload_matrix", mat_flat, exp_mat);
    mat_ready = 1'b1;
    tick();
    mat_ready = 1'b0;

    // ---------------- reset mid-LOAD ----------------
    start = 1'b1;
    size  = 3'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hA0 + i);
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_busy", {199'd0, busy}, 200'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_flat",     mat_flat, 200'd0);
    chk("midrst_busy",     {199'd0, busy},      200'd0);
    chk("midrst_in_ready", {199'd0, in_ready},  200'd0);
    chk("midrst_valid",    {199'd0, mat_valid}, 200'd0);
    tick();
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    size  = 3'd4;
    tick();
    start = 1'b0;
    exp_mat = '0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hF0 + i);
      put_exp(i, 4, 8'(8'hF0 + i));
      tick();
    end
    in_valid = 1'b0;
    chk("fresh4_valid",  {199'd0, mat_valid}, 200'd1);
    chk("fresh4_matrix", mat_flat, exp_mat);
    mat_ready = 1'b1;
    tick();
    mat_ready = 1'b0;
    chk("fresh4_release", {199'd0, busy}, 200'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Bound on total runtime so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
